// File: rtl/fir_cmplx_pkg.sv
// Shared types, default channel taps and the dequantiser for the complex FIR.
// Widths up to 32 bits are supported; products are handled in 64 bits.
package fir_cmplx_pkg;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam int MAX_DW       = 32;
    localparam int DEFAULT_TAPS = 20;

    // Channel-select low-pass taps, Q10.
    localparam logic signed [31:0] CHANNEL_COEFFS_REAL [DEFAULT_TAPS] = '{
        -12, -31, -18,  40,  97,  52, -120, -245, -35, 610,
        590, -41, -230, -113, 49,  91,  38,  -17, -29,  -9
    };

    localparam logic signed [31:0] CHANNEL_COEFFS_IMAG [DEFAULT_TAPS] = '{
          5,  -8,  14,  21, -33, -47,  26,  88,  61, -102,
        -97,  55,  80,  19, -30, -36,  -4,  11,   9,   -3
    };

    // Signed divide by 2^qbits, rounding toward zero (bias negatives before the shift).
    function automatic logic signed [63:0] dequantize(input logic signed [63:0] prod,
                                                      input int qbits);
        logic signed [63:0] bias;
        bias = (prod < 0) ? ((64'sd1 <<< qbits) - 64'sd1) : 64'sd0;
        return (prod + bias) >>> qbits;
    endfunction

    // Taps beyond the default table read as zero.
    function automatic logic signed [31:0] default_tap_re(input int idx);
        return (idx < DEFAULT_TAPS) ? CHANNEL_COEFFS_REAL[idx] : 32'sd0;
    endfunction

    function automatic logic signed [31:0] default_tap_im(input int idx);
        return (idx < DEFAULT_TAPS) ? CHANNEL_COEFFS_IMAG[idx] : 32'sd0;
    endfunction

endpackage

// File: rtl/cmplx_mac.sv
// One complex multiply, dequantise and wrapping accumulate per enabled cycle.
module cmplx_mac
    import fir_cmplx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int QUANT_BITS = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] h_re,
    input  logic signed [DATA_WIDTH-1:0] h_im,
    input  logic signed [DATA_WIDTH-1:0] x_re,
    input  logic signed [DATA_WIDTH-1:0] x_im,
    output logic signed [DATA_WIDTH-1:0] acc_re,
    output logic signed [DATA_WIDTH-1:0] acc_im
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]         prod_re;
    logic signed [PW-1:0]         prod_im;
    logic signed [DATA_WIDTH-1:0] term_re;
    logic signed [DATA_WIDTH-1:0] term_im;

    // Full-width complex product, then scale back to the sample format.
    always_comb begin
        prod_re = h_re * x_re - h_im * x_im;
        prod_im = h_re * x_im + h_im * x_re;
        term_re = DATA_WIDTH'(dequantize(64'(prod_re), QUANT_BITS));
        term_im = DATA_WIDTH'(dequantize(64'(prod_im), QUANT_BITS));
    end

    // Accumulator wraps modulo 2^DATA_WIDTH; clear wins over enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (clear) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (en) begin
            acc_re <= acc_re + term_re;
            acc_im <= acc_im + term_im;
        end
    end

endmodule

// File: rtl/fir_cmplx_decim.sv
// Complex FIR with integer decimation: DECIM pops fill the sample line, then
// NUM_TAPS single-tap MAC cycles, then one push downstream.
// Optional FIR_CMPLX_COEF_LOAD_EN: taps held in a writable register bank.
//
// state  | meaning
// S_FILL | popping upstream samples into the shift register
// S_MAC  | one complex tap per cycle into the accumulators
// S_OUT  | result presented, waiting for room downstream
module fir_cmplx_decim
    import fir_cmplx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 20,
    parameter int DECIM      = 1,
    parameter int QUANT_BITS = 10
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic signed [DATA_WIDTH-1:0]        i_in,
    input  logic signed [DATA_WIDTH-1:0]        q_in,
    input  logic                                in_empty,
    output logic                                in_rd_en,
    output logic signed [DATA_WIDTH-1:0]        y_real,
    output logic signed [DATA_WIDTH-1:0]        y_imag,
    input  logic                                out_full,
    output logic                                out_wr_en
`ifdef FIR_CMPLX_COEF_LOAD_EN
    ,
    input  logic                                coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]         coef_addr,
    input  logic signed [DATA_WIDTH-1:0]        coef_re,
    input  logic signed [DATA_WIDTH-1:0]        coef_im,
    output logic                                coef_ack
`endif
);

    localparam int TW = $clog2(NUM_TAPS);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    state_t                       state;
    state_t                       state_next;
    logic signed [DATA_WIDTH-1:0] x_re [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] x_im [NUM_TAPS];
    logic [TW-1:0]                tap_cnt;
    logic [CW-1:0]                pop_cnt;
    logic                         pop;
    logic                         write;
    logic                         last_pop;
    logic                         last_tap;
    logic                         mac_clear;
    logic                         mac_en;
    logic signed [DATA_WIDTH-1:0] h_re_t;
    logic signed [DATA_WIDTH-1:0] h_im_t;
    logic signed [DATA_WIDTH-1:0] x_re_t;
    logic signed [DATA_WIDTH-1:0] x_im_t;

    assign last_pop = (pop_cnt == CW'(DECIM - 1));
    assign last_tap = (tap_cnt == TW'(NUM_TAPS - 1));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_FILL;
        else        state <= state_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        write      = 1'b0;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        case (state)
            S_FILL: begin
                pop = !in_empty;
                if (pop && last_pop) begin
                    state_next = S_MAC;
                    mac_clear  = 1'b1;
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (last_tap) state_next = S_OUT;
            end
            S_OUT: begin
                write = !out_full;
                if (write) state_next = S_FILL;
            end
            default: state_next = S_FILL;
        endcase
    end

    // Strobes are forced low while reset is held so nothing moves in either FIFO.
    assign in_rd_en  = reset && pop;
    assign out_wr_en = reset && write;

    // Pop counter is kept across empty stalls and wraps on the DECIM-th pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        pop_cnt <= '0;
        else if (pop)      pop_cnt <= last_pop ? '0 : pop_cnt + 1'b1;
    end

    // Tap index runs only while accumulating.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  tap_cnt <= '0;
        else if (state != S_MAC)     tap_cnt <= '0;
        else if (!last_tap)          tap_cnt <= tap_cnt + 1'b1;
        else                         tap_cnt <= '0;
    end

    // Sample delay line: newest sample at index 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_re[k] <= '0;
                x_im[k] <= '0;
            end
        end else if (pop) begin
            x_re[0] <= i_in;
            x_im[0] <= q_in;
            for (int k = 1; k < NUM_TAPS; k++) begin
                x_re[k] <= x_re[k-1];
                x_im[k] <= x_im[k-1];
            end
        end
    end

    assign x_re_t = x_re[tap_cnt];
    assign x_im_t = x_im[tap_cnt];

`ifdef FIR_CMPLX_COEF_LOAD_EN
    logic signed [DATA_WIDTH-1:0] h_re_bank [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] h_im_bank [NUM_TAPS];

    // Writes are refused mid-MAC so a result never mixes old and new taps.
    always_comb begin
        coef_ack = reset && coef_wr_en && (state != S_MAC) && (int'(coef_addr) < NUM_TAPS);
    end

    // Tap bank, loaded with the package defaults on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                h_re_bank[k] <= DATA_WIDTH'(default_tap_re(k));
                h_im_bank[k] <= DATA_WIDTH'(default_tap_im(k));
            end
        end else if (coef_ack) begin
            h_re_bank[coef_addr] <= coef_re;
            h_im_bank[coef_addr] <= coef_im;
        end
    end

    assign h_re_t = h_re_bank[tap_cnt];
    assign h_im_t = h_im_bank[tap_cnt];
`else
    assign h_re_t = DATA_WIDTH'(default_tap_re(int'(tap_cnt)));
    assign h_im_t = DATA_WIDTH'(default_tap_im(int'(tap_cnt)));
`endif

    cmplx_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUANT_BITS (QUANT_BITS)
    ) u_mac (
        .clock  (clock),
        .reset  (reset),
        .clear  (mac_clear),
        .en     (mac_en),
        .h_re   (h_re_t),
        .h_im   (h_im_t),
        .x_re   (x_re_t),
        .x_im   (x_im_t),
        .acc_re (y_real),
        .acc_im (y_imag)
    );

endmodule

// File: tb/tb_fir_cmplx_decim.sv
// Scoreboard bench for fir_cmplx_decim: a driver models both FIFOs and a
// reference filter; a monitor compares every presented result cycle by cycle.
module tb_fir_cmplx_decim;

    localparam int DW = 32;
    localparam int NT = 20;
    localparam int DC = 3;
    localparam int QB = 10;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic signed [DW-1:0] i_in = '0;
    logic signed [DW-1:0] q_in = '0;
    logic                 in_empty = 1'b1;
    logic                 in_rd_en;
    logic signed [DW-1:0] y_real;
    logic signed [DW-1:0] y_imag;
    logic                 out_full = 1'b0;
    logic                 out_wr_en;

    fir_cmplx_decim #(
        .DATA_WIDTH (DW),
        .NUM_TAPS   (NT),
        .DECIM      (DC),
        .QUANT_BITS (QB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_in      (i_in),
        .q_in      (q_in),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .y_real    (y_real),
        .y_imag    (y_imag),
        .out_full  (out_full),
        .out_wr_en (out_wr_en)
    );

    always #5 clock = ~clock;

    typedef struct { int re; int im; } samp_t;
    typedef struct { int re; int im; int pop_cyc; } exp_t;

    samp_t in_q[$];
    exp_t  exp_q[$];
    int    hist_re[$];
    int    hist_im[$];
    int    pops_m = 0;
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    p_empty = 0;
    int    p_full = 0;
    bit    force_full = 1'b0;
    bit    rst_drv = 1'b0;

    task automatic check(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: y = sum_t DQ(h[t] * x[n-t]) with integer division toward zero.
    task automatic model_accept(input int re, input int im);
        exp_t   e;
        longint scale, xr, xi, hr, hi;
        int     ar, ai;
        hist_re.push_front(re);
        hist_im.push_front(im);
        if (hist_re.size() > NT) begin
            void'(hist_re.pop_back());
            void'(hist_im.pop_back());
        end
        pops_m++;
        if (pops_m == DC) begin
            pops_m = 0;
            scale = longint'(1) << QB;
            ar = 0;
            ai = 0;
            for (int t = 0; t < NT; t++) begin
                xr = (t < hist_re.size()) ? longint'(hist_re[t]) : 0;
                xi = (t < hist_im.size()) ? longint'(hist_im[t]) : 0;
                hr = longint'(fir_cmplx_pkg::CHANNEL_COEFFS_REAL[t]);
                hi = longint'(fir_cmplx_pkg::CHANNEL_COEFFS_IMAG[t]);
                ar += int'((hr * xr - hi * xi) / scale);
                ai += int'((hr * xi + hi * xr) / scale);
            end
            e.re = ar;
            e.im = ai;
            e.pop_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_clear();
        hist_re.delete();
        hist_im.delete();
        pops_m = 0;
        exp_q.delete();
    endtask

    // One clock of upstream/downstream FIFO behaviour; pops are sampled after inputs settle.
    task automatic cycle();
        samp_t s;
        @(negedge clock);
        cyc++;
        reset    = rst_drv;
        in_empty = (in_q.size() == 0) || ($urandom_range(99) < p_empty);
        i_in     = (in_q.size() != 0) ? in_q[0].re : 0;
        q_in     = (in_q.size() != 0) ? in_q[0].im : 0;
        out_full = force_full || ($urandom_range(99) < p_full);
        #1;
        if (in_rd_en) begin
            if (in_empty) check("pop_while_empty", 1, 0);
            else begin
                s = in_q.pop_front();
                model_accept(s.re, s.im);
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
            cycle();
            n++;
        end
        if (in_q.size() != 0 || exp_q.size() != 0) check("drain_timeout", n, -1);
    endtask

    function automatic int rand_val();
        case ($urandom_range(3))
            0: return int'($urandom);
            1: return int'($urandom_range(4000)) - 2000;
            2: return ($urandom_range(1) != 0) ? 32'sh7fffffff : 32'sh80000000;
            default: return 0;
        endcase
    endfunction

    task automatic push_random(input int n);
        samp_t s;
        for (int i = 0; i < n; i++) begin
            s.re = rand_val();
            s.im = rand_val();
            in_q.push_back(s);
        end
    endtask

    // Monitor: once a result is due it must be presented, held, and pushed iff room.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                if (exp_q.size() != 0 && cyc >= exp_q[0].pop_cyc + NT + 1) begin
                    check("y_real", longint'(y_real), longint'(exp_q[0].re));
                    check("y_imag", longint'(y_imag), longint'(exp_q[0].im));
                    check("out_wr_en_when_due", longint'(out_wr_en), longint'(!out_full));
                    if (out_wr_en) void'(exp_q.pop_front());
                end else if (out_wr_en) begin
                    check("unexpected_write", 1, 0);
                end
            end
        end
    end

    initial begin
        samp_t s;
        int    n;

        // Reset: strobes and outputs low even with data waiting upstream.
        s.re = 1024;
        s.im = 0;
        in_q.push_back(s);
        for (int i = 0; i < DC * NT - 1; i++) begin
            s.re = 0;
            s.im = 0;
            in_q.push_back(s);
        end
        rst_drv = 1'b0;
        cycle();
        check("rst_in_rd_en", longint'(in_rd_en), 0);
        check("rst_out_wr_en", longint'(out_wr_en), 0);
        check("rst_y_real", longint'(y_real), 0);
        check("rst_y_imag", longint'(y_imag), 0);
        repeat (2) cycle();
        rst_drv = 1'b1;

        // Impulse through a free-running pipe: exact throughput and latency.
        p_empty = 0;
        p_full  = 0;
        drain(3000);

        // Random data with random empty/full gaps.
        p_empty = 25;
        p_full  = 25;
        push_random(150);
        drain(20000);

        // Long downstream stall on a presented result.
        p_empty = 0;
        p_full  = 0;
        push_random(30);
        n = 0;
        while (!(exp_q.size() != 0 && cyc >= exp_q[0].pop_cyc + NT) && n < 500) begin
            cycle();
            n++;
        end
        if (n >= 500) check("stall_setup_timeout", n, -1);
        force_full = 1'b1;
        repeat (50) cycle();
        force_full = 1'b0;
        drain(3000);

        // Reset at MAC cycle 7 discards the partial result.
        push_random(30);
        n = 0;
        while (!(exp_q.size() != 0 && exp_q[$].pop_cyc == cyc) && n < 500) begin
            cycle();
            n++;
        end
        if (n >= 500) check("mac_setup_timeout", n, -1);
        repeat (7) cycle();
        rst_drv = 1'b0;
        cycle();
        check("midmac_in_rd_en", longint'(in_rd_en), 0);
        check("midmac_out_wr_en", longint'(out_wr_en), 0);
        check("midmac_y_real", longint'(y_real), 0);
        check("midmac_y_imag", longint'(y_imag), 0);
        model_clear();
        repeat (2) cycle();
        rst_drv = 1'b1;
        p_empty = 20;
        p_full  = 30;
        push_random(90);
        drain(20000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
